// File: rtl/payload_tx_arbiter_if.sv
// Payload arbiter bundle: requester side plus TX serializer side.
// The arbiter takes the master view; producers and serializer take slave.
interface payload_tx_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int PAYLOAD_W = 44
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*PAYLOAD_W-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic                       tx_start;
  logic [PAYLOAD_W-1:0]       tx_data;
  logic                       tx_busy;
  logic                       tx_done;
  logic [ID_W-1:0]            grant_id;
  logic                       timeout_err;
  logic [15:0]                frames_sent;

  modport master (
    input  req_valid,
    input  req_data,
    input  tx_busy,
    input  tx_done,
    output req_ready,
    output tx_start,
    output tx_data,
    output grant_id,
    output timeout_err,
    output frames_sent
  );

  modport slave (
    output req_valid,
    output req_data,
    output tx_busy,
    output tx_done,
    input  req_ready,
    input  tx_start,
    input  tx_data,
    input  grant_id,
    input  timeout_err,
    input  frames_sent
  );
endinterface

// File: rtl/payload_tx_arbiter.sv
// Round-robin arbiter sharing one Ethernet TX serializer among producers.
// Handles launch handshake, inter-frame gap and stuck-serializer timeout.
module payload_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int PAYLOAD_W   = 44,
  parameter int IFG_CYCLES  = 48,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  payload_tx_arbiter_if.master bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX =
    (TIMEOUT_CYC > IFG_CYCLES) ? TIMEOUT_CYC : IFG_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } state_t;

  state_t state;
  state_t state_d;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_d;
  logic [ID_W-1:0]      last;
  logic [ID_W-1:0]      last_d;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      grant_d;
  logic [ID_W-1:0]      win;
  logic [ID_W-1:0]      cand;
  logic                 hit;
  int                   sel;
  logic [PAYLOAD_W-1:0] data_q;
  logic [PAYLOAD_W-1:0] data_d;
  logic [N_REQ-1:0]     ready_q;
  logic [N_REQ-1:0]     ready_d;
  logic                 start_q;
  logic                 start_d;
  logic                 tmo_q;
  logic                 tmo_d;
  logic [15:0]          frames;
  logic                 frame_inc;
  logic                 tmo_hit;
  logic                 gap_end;

  assign bus.req_ready   = ready_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_data     = data_q;
  assign bus.grant_id    = grant;
  assign bus.timeout_err = tmo_q;
  assign bus.frames_sent = frames;

  // Search last+1, last+2, ... so the previous winner goes last.
  always_comb begin
    win  = '0;
    hit  = 1'b0;
    sel  = 0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sel  = (int'(last) + k) % N_REQ;
      cand = ID_W'(sel);
      if (!hit && bus.req_valid[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  // A done pulse on the expiry cycle wins over the timeout.
  assign tmo_hit = (state == WAIT_DONE) && !bus.tx_done &&
                   (cnt == CW'(TIMEOUT_CYC - 1));
  assign gap_end = (state == GAP) &&
                   (cnt == CW'(IFG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (hit) state_d = LAUNCH;
      LAUNCH:    if (!bus.tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done || tmo_hit) state_d = GAP;
      GAP:       if (gap_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d   = '0;
    start_d   = 1'b0;
    tmo_d     = 1'b0;
    frame_inc = 1'b0;
    data_d    = data_q;
    last_d    = last;
    grant_d   = grant;
    cnt_d     = cnt;
    unique case (state)
      IDLE: begin
        if (hit) begin
          ready_d[win] = 1'b1;
          data_d  = bus.req_data[int'(win)*PAYLOAD_W +: PAYLOAD_W];
          last_d  = win;
          grant_d = win;
        end
      end
      LAUNCH: begin
        if (!bus.tx_busy) begin
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          frame_inc = 1'b1;
          data_d    = '0;
          cnt_d     = '0;
        end else if (tmo_hit) begin
          tmo_d  = 1'b1;
          data_d = '0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        cnt_d = gap_end ? '0 : cnt + 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      last    <= ID_W'(N_REQ - 1);
      grant   <= '0;
      data_q  <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      frames  <= '0;
    end else begin
      cnt     <= cnt_d;
      last    <= last_d;
      grant   <= grant_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      if (frame_inc) begin
        frames <= frames + 16'd1;
      end
    end
  end
endmodule
